// File: rtl/swo_pkg.sv
// SWO transmit scheduler shared definitions.
// FSM states and FIFO level sizing helpers.
package swo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam int DEF_FIFO_DEPTH = 8;

  // Level needs one bit more than the address so "full" is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_LVL_W = lvl_w(DEF_FIFO_DEPTH);

endpackage

// File: rtl/swo_byte_fifo.sv
// Single-clock byte FIFO for the SWO scheduler.
// Flush clears pointers; a write during flush is dropped.
module swo_byte_fifo
  import swo_pkg::*;
#(
  parameter int pDEPTH = 8
) (
  input  logic                        swo_clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic                        rd_en,
  output logic [7:0]                  rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [lvl_w(pDEPTH)-1:0]    level
);

  localparam int AW = $clog2(pDEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(pDEPTH);

  logic [7:0]  mem [pDEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_rd;
  logic        do_wr;

  // Occupancy, flags and accept decisions from the pointer difference.
  always_comb begin
    level   = wr_ptr - rd_ptr;
    empty   = (wr_ptr == rd_ptr);
    full    = (level == FULL_LVL);
    do_rd   = rd_en & ~empty;
    do_wr   = wr_en & (~full | do_rd);
    rd_data = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; flush wins over any read or write this cycle.
  always_ff @(posedge swo_clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge swo_clk) begin
    if (!reset && !flush && do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/swo_tx_scheduler.sv
// SWO byte scheduler feeding the uart_core transmit handshake.
// Queues trace bytes, launches one at a time, spaces them by a gap.
module swo_tx_scheduler
  import swo_pkg::*;
#(
  parameter int          pFIFO_DEPTH = 8,
  parameter int          pGAP_W      = 8,
  parameter logic [15:0] pTIMEOUT    = 16'd4096
) (
  input  logic                           swo_clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           flush,
  input  logic [pGAP_W-1:0]              gap_cycles,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_valid,
  output logic                           txd_syn,
  output logic [7:0]                     txd_data,
  input  logic                           txd_ack,
  output logic                           busy,
  output logic [lvl_w(pFIFO_DEPTH)-1:0]  fifo_level,
  output logic                           overflow,
  output logic                           ack_error,
  output logic [15:0]                    bytes_sent
);

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       tmo_q;
  logic [pGAP_W-1:0] gap_q;
  logic [7:0]        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              launch;
  logic              tmo_hit;
  logic              in_wait;
  logic              good_ack;

  swo_byte_fifo #(
    .pDEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .swo_clk (swo_clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (byte_valid),
    .wr_data (byte_in),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // State register.
  always_ff @(posedge swo_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a flush blocks a launch decision on its cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enable && !fifo_empty && !flush) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (txd_ack) begin
          state_d = (gap_cycles == '0) ? IDLE : GAP;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q <= pGAP_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs and handshake qualifiers.
  always_comb begin
    txd_syn  = (state_q == LAUNCH);
    pop      = (state_q == LAUNCH);
    launch   = (state_q == IDLE) && (state_d == LAUNCH);
    in_wait  = (state_q == WAIT_ACK);
    good_ack = in_wait && txd_ack;
    tmo_hit  = (tmo_q == pTIMEOUT - 16'd1);
    busy     = (state_q != IDLE) || !fifo_empty;
  end

  // Holding register: captured on entry to LAUNCH so data is valid with syn.
  always_ff @(posedge swo_clk) begin
    if (reset)       txd_data <= 8'h00;
    else if (launch) txd_data <= head;
  end

  // Ack timeout counter, restarted by every launch.
  always_ff @(posedge swo_clk) begin
    if (reset)        tmo_q <= '0;
    else if (pop)     tmo_q <= '0;
    else if (in_wait) tmo_q <= tmo_q + 16'd1;
  end

  // Inter-byte gap counter, loaded from gap_cycles at a good ack.
  always_ff @(posedge swo_clk) begin
    if (reset) begin
      gap_q <= '0;
    end else if (good_ack && gap_cycles != '0) begin
      gap_q <= gap_cycles;
    end else if (state_q == GAP) begin
      gap_q <= gap_q - 1'b1;
    end
  end

  // Acknowledged-byte counter, wraps naturally.
  always_ff @(posedge swo_clk) begin
    if (reset)         bytes_sent <= '0;
    else if (good_ack) bytes_sent <= bytes_sent + 16'd1;
  end

  // Sticky overflow: a write refused because the FIFO stayed full.
  always_ff @(posedge swo_clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (byte_valid && !flush && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Sticky handshake error: stray ack or ack timeout.
  always_ff @(posedge swo_clk) begin
    if (reset) begin
      ack_error <= 1'b0;
    end else if (txd_ack && !in_wait) begin
      ack_error <= 1'b1;
    end else if (in_wait && !txd_ack && tmo_hit) begin
      ack_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_swo_tx_scheduler.sv
// Randomized bench for swo_tx_scheduler.
// Reference model tracks a byte queue and event timestamps.
module tb_swo_tx_scheduler;

  localparam int DEPTH = 8;
  localparam int T     = 64;

  logic        swo_clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  gap_cycles = 8'd0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        txd_syn;
  logic [7:0]  txd_data;
  logic        txd_ack = 1'b0;
  logic        busy;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic        ack_error;
  logic [15:0] bytes_sent;

  always #5 swo_clk = ~swo_clk;

  swo_tx_scheduler #(
    .pFIFO_DEPTH (DEPTH),
    .pGAP_W      (8),
    .pTIMEOUT    (16'(T))
  ) dut (
    .swo_clk    (swo_clk),
    .reset      (reset),
    .enable     (enable),
    .flush      (flush),
    .gap_cycles (gap_cycles),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .txd_syn    (txd_syn),
    .txd_data   (txd_data),
    .txd_ack    (txd_ack),
    .busy       (busy),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .ack_error  (ack_error),
    .bytes_sent (bytes_sent)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  q[$];
  int          cyc = 0;
  int          launch_c = -1;
  int          free_c = 0;
  int          ack_at = -1;
  bit          inflight = 0;
  logic [7:0]  m_data = 8'h00;
  logic [15:0] m_sent = 16'd0;
  bit          m_ovf = 0;
  bit          m_err = 0;

  bit          en_s = 0;
  logic [7:0]  gap_s = 8'd0;
  int          ack_lo = 1;
  int          ack_hi = 20;
  int          spur = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] b,
                      input bit f, input bit r);
    bit         ack;
    bit         wait_ph;
    bit         idle;
    bit         decide;
    logic [7:0] hd;
    @(negedge swo_clk);
    check("syn", 32'(txd_syn), 32'(cyc == launch_c));
    check("data", 32'(txd_data), 32'(m_data));
    check("level", 32'(fifo_level), 32'(q.size()));
    check("busy", 32'(busy),
          32'(inflight || cyc < free_c || q.size() != 0));
    check("ovf", 32'(overflow), 32'(m_ovf));
    check("err", 32'(ack_error), 32'(m_err));
    check("sent", 32'(bytes_sent), 32'(m_sent));
    if (cyc == launch_c) begin
      if (ack_hi == 0) ack_at = -1;
      else ack_at = cyc + int'($urandom_range(ack_hi, ack_lo));
    end
    ack = (cyc == ack_at) || (int'($urandom_range(999, 0)) < spur);
    reset      = r;
    enable     = en_s;
    gap_cycles = gap_s;
    flush      = f;
    byte_valid = v;
    byte_in    = b;
    txd_ack    = ack;
    if (r) begin
      q.delete();
      inflight = 0;
      launch_c = -1;
      free_c   = cyc + 1;
      ack_at   = -1;
      m_data   = 8'h00;
      m_sent   = 16'd0;
      m_ovf    = 0;
      m_err    = 0;
    end else begin
      wait_ph = inflight && cyc > launch_c;
      idle    = !inflight && cyc >= free_c;
      decide  = idle && en_s && q.size() != 0 && !f;
      hd      = (q.size() != 0) ? q[0] : 8'h00;
      if (ack) begin
        if (wait_ph) begin
          m_sent++;
          inflight = 0;
          free_c = cyc + int'(gap_s) + 1;
        end else begin
          m_err = 1;
        end
      end else if (wait_ph && cyc == launch_c + T) begin
        m_err = 1;
        inflight = 0;
        free_c = cyc + 1;
      end
      if (f) begin
        q.delete();
      end else begin
        if (cyc == launch_c) void'(q.pop_front());
        if (v) begin
          if (q.size() < DEPTH) q.push_back(b);
          else m_ovf = 1;
        end
      end
      if (decide) begin
        launch_c = cyc + 1;
        inflight = 1;
        m_data   = hd;
      end
    end
    cyc++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) tick(0, 8'h00, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge swo_clk);
    repeat (3) tick(0, 8'h00, 0, 1);

    en_s = 1; gap_s = 0; ack_lo = 20; ack_hi = 20;
    tick(1, 8'hA5, 0, 0);
    idle_n(30);
    check("single_sent", 32'(bytes_sent), 32'd1);

    gap_s = 3; ack_lo = 10; ack_hi = 10;
    tick(1, 8'h01, 0, 0);
    tick(1, 8'h02, 0, 0);
    tick(1, 8'h03, 0, 0);
    idle_n(60);
    check("gap_sent", 32'(bytes_sent), 32'd4);

    tick(0, 8'h00, 0, 1);
    en_s = 0; gap_s = 0; ack_lo = 3; ack_hi = 6;
    for (int i = 0; i < 9; i++) tick(1, 8'(8'h10 + i), 0, 0);
    check("ovf_level", 32'(fifo_level), 32'd8);
    en_s = 1;
    idle_n(150);
    check("ovf_sent", 32'(bytes_sent), 32'd8);

    tick(0, 8'h00, 0, 1);
    en_s = 0;
    for (int i = 0; i < 8; i++) tick(1, 8'(8'h40 + i), 0, 0);
    en_s = 1;
    tick(0, 8'h00, 0, 0);
    tick(1, 8'h48, 0, 0);
    tick(0, 8'h00, 0, 0);
    check("pop_full_level", 32'(fifo_level), 32'd8);
    check("pop_full_ovf", 32'(overflow), 32'd0);
    idle_n(120);

    tick(0, 8'h00, 0, 1);
    ack_hi = 0;
    tick(1, 8'h77, 0, 0);
    tick(1, 8'h78, 0, 0);
    idle_n(T);
    ack_lo = 5; ack_hi = 5;
    idle_n(20);
    check("tmo_sent", 32'(bytes_sent), 32'd1);

    tick(0, 8'h00, 0, 1);
    ack_lo = 30; ack_hi = 30;
    for (int i = 0; i < 5; i++) tick(1, 8'(8'h80 + i), 0, 0);
    idle_n(5);
    tick(0, 8'h00, 1, 0);
    idle_n(40);
    check("flush_sent", 32'(bytes_sent), 32'd1);

    tick(1, 8'h91, 0, 0);
    tick(1, 8'h92, 0, 0);
    idle_n(10);
    tick(0, 8'h00, 0, 1);
    idle_n(40);

    ack_lo = 1; ack_hi = T + 8; spur = 3;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(99, 0) < 2) en_s = ~en_s;
      if ($urandom_range(99, 0) < 3) gap_s = 8'($urandom_range(5, 0));
      tick($urandom_range(99, 0) < 30, 8'($urandom),
           $urandom_range(99, 0) < 1, $urandom_range(999, 0) < 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/swo_tx_scheduler.md
Name: swo_tx_scheduler

Overview:
- Sequences byte transmission on the SWO UART transmitter (uart_core Tx side, txd_syn/txd_data/txd_ack) from a stream of trace bytes.
- Buffers incoming bytes in a small FIFO, issues one txd_syn per byte, waits for completion, enforces a programmable inter-byte gap, and flags overflow and handshake errors.
- Sits between the trace byte source (two TRACEDATA nibbles packed {hi,lo}) and uart_core, all in the swo_clk domain.

Parameters:
- pFIFO_DEPTH, 8, FIFO entries; power of 2, minimum 2.
- pGAP_W, 8, width of the inter-byte gap counter.
- pTIMEOUT, 16'd4096, swo_clk cycles allowed between txd_syn and txd_ack before a timeout error.

Ports:
- swo_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  1 = scheduler may launch bytes; 0 = finish the byte in flight, then hold.
- flush  in  1  one-cycle pulse; empties the FIFO (does not abort the byte in flight).
- gap_cycles  in  pGAP_W  idle swo_clk cycles inserted after each txd_ack.
- byte_in  in  8  trace byte, {TRACEDATA_hi, TRACEDATA_lo}.
- byte_valid  in  1  one-cycle strobe; byte_in is written to the FIFO if not full.
- txd_syn  out  1  one-cycle launch pulse to uart_core.
- txd_data  out  8  byte to uart_core; stable from the txd_syn cycle until txd_ack.
- txd_ack  in  1  one-cycle pulse from uart_core when the stop bit completes.
- busy  out  1  state != IDLE or FIFO not empty.
- fifo_level  out  $clog2(pFIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; byte_valid arrived while the FIFO was full (byte dropped).
- ack_error  out  1  sticky; timeout expired, or txd_ack arrived outside WAIT_ACK.
- bytes_sent  out  16  count of acknowledged bytes; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset: every output is 0; the FIFO is empty; state is IDLE; sticky flags and the counter are cleared. Reset asserted mid-byte abandons the byte with no further txd_syn. uart_core shares the same reset.
- FIFO: write on byte_valid & !full. Read (pop) in the cycle txd_syn is asserted. A simultaneous write and read while full is allowed, since the pop frees the slot; in that case no overflow is flagged. Pointers wrap modulo pFIFO_DEPTH; level is computed from the pointer difference with an extra bit.
- Flush: clears the pointers. If byte_valid arrives in the same cycle as flush, that byte is discarded.
- FSM:
  - IDLE: if enable & !empty, go to LAUNCH.
  - LAUNCH: txd_syn = 1 for exactly this cycle; txd_data is loaded from the FIFO head into a holding register; pop. Go to WAIT_ACK and clear the timeout counter.
  - WAIT_ACK:
    - On txd_ack: bytes_sent += 1. If gap_cycles == 0, go to IDLE; else load the gap counter with gap_cycles and go to GAP.
    - If the timeout counter reaches pTIMEOUT-1 without txd_ack: set ack_error and go to IDLE; the byte is counted as lost.
  - GAP: decrement each cycle; when the counter reaches 1, go to IDLE. Total idle time from txd_ack to the next txd_syn is gap_cycles+2 cycles (gap cycles, then IDLE, then LAUNCH).
- Minimum spacing with gap_cycles = 0: txd_ack at cycle N gives the next txd_syn at N+2.
- txd_ack seen in IDLE, LAUNCH or GAP: set ack_error and otherwise ignore it.
- enable deasserted in WAIT_ACK or GAP: the current sequence completes, then the FSM holds in IDLE.
- txd_data holds its last value in IDLE; it is never driven from the FIFO combinationally.

Decomposition:
- Package swo_pkg: FSM state enum (IDLE, LAUNCH, WAIT_ACK, GAP); localparam for the level width derived from pFIFO_DEPTH.
- Sub-module swo_byte_fifo: synchronous single-clock FIFO with flush, full, empty and level. The FSM, counters and flags stay in swo_tx_scheduler.

Test Plan:
- Single byte: enable=1, gap=0, byte 8'hA5 written, ack returned 20 cycles after syn -> txd_syn once, 2 cycles after the write; txd_data=8'hA5 held until ack; bytes_sent=1; busy drops.
- Back-to-back with gap: gap=3, bytes 01,02,03 written, ack 10 cycles after each syn -> each following syn comes exactly 5 cycles after the prior ack; data in order; bytes_sent=3.
- Overflow: enable=0, 9 writes with pFIFO_DEPTH=8 -> fifo_level=8, overflow=1, ninth byte absent. After enable=1, exactly 8 bytes are sent in order.
- Full with simultaneous pop: FIFO full, byte_valid in the LAUNCH cycle -> no overflow; level stays 8.
- Timeout: ack withheld -> ack_error set at syn+pTIMEOUT; FSM returns to IDLE and launches the next queued byte; bytes_sent unchanged.
- Flush and reset mid-byte: flush during WAIT_ACK with 4 queued -> level=0, in-flight ack still counted. Reset in WAIT_ACK -> all outputs 0 next cycle, no txd_syn afterwards.
